// File: rtl/hni_rxchan_lcrd_pkg.sv
// ---------------------------------------------------------------------------
// hni_rxchan_lcrd_pkg
// Shared definitions for the HNI receive-channel link-layer endpoint:
//   - link_state_e : link state encodings (STOP / RUN / DRAIN)
//   - CHIE_RSP_FLIT_W : default flit width (CHI-E RSP channel)
//   - LCRD_MAX_CHI : most L-credits a CHI transmitter may hold
//   - LCRDRET_OPC_DEF : opcode value of an LCrdReturn flit
//   - CRD_CNT_W : width of the credit counter
// ---------------------------------------------------------------------------
`ifndef CHIE_RSP_FLIT_WIDTH
`define CHIE_RSP_FLIT_WIDTH 65
`endif

package hni_rxchan_lcrd_pkg;

  typedef enum logic [1:0] {
    LINK_STOP  = 2'b00,
    LINK_RUN   = 2'b01,
    LINK_DRAIN = 2'b10
  } link_state_e;

  localparam int CHIE_RSP_FLIT_W = `CHIE_RSP_FLIT_WIDTH;
  localparam int LCRD_MAX_CHI    = 15;
  localparam int LCRDRET_OPC_DEF = 0;
  localparam int CRD_CNT_W       = 4;

endpackage

// File: rtl/hni_rxchan_lcrd_sync_fifo.sv
// ---------------------------------------------------------------------------
// hni_rxchan_lcrd_sync_fifo
// Single-clock FIFO with occupancy count; reusable for TX channels.
// Writes are ignored when full, reads are ignored when empty.
// The head entry is presented combinationally on rd_data.
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-low reset (pointers and count to 0)
//   wr_en    in   push wr_data at the tail
//   wr_data  in   WIDTH-bit entry to push
//   rd_en    in   pop the head entry
//   rd_data  out  head entry (stale data when empty)
//   count    out  number of entries held
//   full     out  count == DEPTH
//   empty    out  count == 0
// ---------------------------------------------------------------------------
module hni_rxchan_lcrd_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_wr;
  logic             do_rd;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  assign count   = cnt;

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH
  // without any compare logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/hni_rxchan_lcrd.sv
// ---------------------------------------------------------------------------
// hni_rxchan_lcrd
// CHI-E receive-channel link-layer endpoint for HNI (one per REQ/RSP/DAT).
// Grants L-credits up to the buffer capacity, buffers received flits,
// recycles credits as the consumer drains the buffer, absorbs LCrdReturn
// flits, runs the STOP/RUN/DRAIN link state machine and flags protocol
// errors (flit without credit, overflow).
//
// Optional build macro:
//   HNI_RXCHAN_BYPASS_EN - when defined, a flit arriving at an empty buffer
//   while the consumer is ready is presented combinationally on out_flit in
//   the same cycle and never written into the FIFO.
//
// Ports:
//   clk             in   clock
//   rst             in   asynchronous active-low reset
//   link_act_req    in   level request to bring the link up
//   link_deact_req  in   level request to take the link down (drain)
//   link_state      out  00 STOP, 01 RUN, 10 DRAIN
//   rxflitv         in   flit valid from the link
//   rxflit          in   flit payload
//   rxlcrdv         out  credit grant to the transmitter (registered)
//   out_valid       out  a flit is available to the consumer
//   out_flit        out  head flit, zero when out_valid is low
//   out_ready       in   consumer accepts the head flit
//   crd_cnt         out  credits currently held by the transmitter
//   fifo_cnt        out  flits buffered
//   proto_err       out  sticky protocol-error flag
// ---------------------------------------------------------------------------
module hni_rxchan_lcrd
  import hni_rxchan_lcrd_pkg::*;
#(
  parameter int FLIT_WIDTH  = CHIE_RSP_FLIT_W,
  parameter int DEPTH       = 4,
  parameter int LCRD_MAX    = LCRD_MAX_CHI,
  parameter int OPC_LSB     = 14,
  parameter int OPC_WIDTH   = 5,
  parameter int LCRDRET_OPC = LCRDRET_OPC_DEF,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  link_act_req,
  input  logic                  link_deact_req,
  output logic [1:0]            link_state,
  input  logic                  rxflitv,
  input  logic [FLIT_WIDTH-1:0] rxflit,
  output logic                  rxlcrdv,
  output logic                  out_valid,
  output logic [FLIT_WIDTH-1:0] out_flit,
  input  logic                  out_ready,
  output logic [CRD_CNT_W-1:0]  crd_cnt,
  output logic [CNT_W-1:0]      fifo_cnt,
  output logic                  proto_err
);

  link_state_e           state_q;
  link_state_e           state_d;
  logic                  rxlcrdv_q;
  logic [CRD_CNT_W-1:0]  crd_cnt_q;
  logic                  proto_err_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_wr;
  logic                  fifo_rd;
  logic [FLIT_WIDTH-1:0] fifo_head;
  logic [CNT_W-1:0]      fifo_count;

  logic                  is_lcrdret;
  logic                  flit_accept;
  logic                  data_flit;
  logic                  bypass;
  logic                  issue;
  logic                  err_event;

  assign is_lcrdret  = (rxflit[OPC_LSB +: OPC_WIDTH] == OPC_WIDTH'(LCRDRET_OPC));
  // A flit is only legal while the transmitter actually holds a credit.
  assign flit_accept = rxflitv && (crd_cnt_q != '0);
  assign data_flit   = flit_accept && !is_lcrdret;

`ifdef HNI_RXCHAN_BYPASS_EN
  assign bypass = data_flit && fifo_empty && out_ready;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_wr = data_flit && !bypass && !fifo_full;
  assign fifo_rd = !fifo_empty && out_ready;

  // The grant still in the rxlcrdv register is counted so the same free
  // slot is never promised twice; crd_cnt only absorbs it on the next edge.
  assign issue = (state_q == LINK_RUN) &&
                 ((int'(crd_cnt_q) + int'(fifo_count) + int'(rxlcrdv_q)) < DEPTH) &&
                 (int'(crd_cnt_q) < LCRD_MAX);

  assign err_event = (rxflitv && (crd_cnt_q == '0)) ||
                     (data_flit && !bypass && fifo_full);

  hni_rxchan_lcrd_sync_fifo #(
    .WIDTH (FLIT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (rxflit),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Consumer view: buffered head first, otherwise the bypassed flit;
  // the data lines are forced to zero whenever nothing is offered.
  always_comb begin
    out_valid = 1'b0;
    out_flit  = '0;
    if (!fifo_empty) begin
      out_valid = 1'b1;
      out_flit  = fifo_head;
    end else if (bypass) begin
      out_valid = 1'b1;
      out_flit  = rxflit;
    end
  end

  // Link state machine. DRAIN only exits to STOP once every outstanding
  // credit has come back and no grant is still on the wire.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LINK_STOP:  if (link_act_req && !link_deact_req) state_d = LINK_RUN;
      LINK_RUN:   if (link_deact_req) state_d = LINK_DRAIN;
      LINK_DRAIN: if ((crd_cnt_q == '0) && !rxlcrdv_q) state_d = LINK_STOP;
      default:    state_d = LINK_STOP;
    endcase
  end

  // Credit bookkeeping: a grant on rxlcrdv and an arriving flit cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LINK_STOP;
      rxlcrdv_q   <= 1'b0;
      crd_cnt_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rxlcrdv_q <= issue;
      case ({rxlcrdv_q, flit_accept})
        2'b10:   crd_cnt_q <= crd_cnt_q + CRD_CNT_W'(1);
        2'b01:   crd_cnt_q <= crd_cnt_q - CRD_CNT_W'(1);
        default: crd_cnt_q <= crd_cnt_q;
      endcase
      if (err_event) proto_err_q <= 1'b1;
    end
  end

  assign link_state = state_q;
  assign rxlcrdv    = rxlcrdv_q;
  assign crd_cnt    = crd_cnt_q;
  assign fifo_cnt   = fifo_count;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_hni_rxchan_lcrd.sv
// ---------------------------------------------------------------------------
// tb_hni_rxchan_lcrd
// Self-checking bench for hni_rxchan_lcrd (DEPTH=4, 32-bit flits, opcode in
// bits [18:14]). Directed scenarios check fixed expectations; a randomized
// phase compares against a queue-based reference model of the credit loop.
// Honours HNI_RXCHAN_BYPASS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_hni_rxchan_lcrd;

  localparam int FW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          link_act_req;
  logic          link_deact_req;
  logic [1:0]    link_state;
  logic          rxflitv;
  logic [FW-1:0] rxflit;
  logic          rxlcrdv;
  logic          out_valid;
  logic [FW-1:0] out_flit;
  logic          out_ready;
  logic [3:0]    crd_cnt;
  logic [CW-1:0] fifo_cnt;
  logic          proto_err;

  int total = 0;
  int bad   = 0;

  // Reference model state: link state as 0/1/2, credits held, grant in
  // flight, buffered flits in arrival order, sticky error.
  int            m_state;
  int            m_crd;
  bit            m_lcrdv;
  bit            m_err;
  logic [FW-1:0] m_q[$];

  always #5 clk = ~clk;

  hni_rxchan_lcrd #(
    .FLIT_WIDTH  (FW),
    .DEPTH       (DEPTH),
    .LCRD_MAX    (15),
    .OPC_LSB     (14),
    .OPC_WIDTH   (5),
    .LCRDRET_OPC (0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .link_act_req   (link_act_req),
    .link_deact_req (link_deact_req),
    .link_state     (link_state),
    .rxflitv        (rxflitv),
    .rxflit         (rxflit),
    .rxlcrdv        (rxlcrdv),
    .out_valid      (out_valid),
    .out_flit       (out_flit),
    .out_ready      (out_ready),
    .crd_cnt        (crd_cnt),
    .fifo_cnt       (fifo_cnt),
    .proto_err      (proto_err)
  );

  function automatic logic [FW-1:0] mk_flit(input logic [4:0] opc, input logic [13:0] lo,
                                            input logic [12:0] hi);
    logic [FW-1:0] f;
    f = {hi, opc, lo};
    return f;
  endfunction

  function automatic bit model_bypass();
`ifdef HNI_RXCHAN_BYPASS_EN
    return (m_q.size() == 0) && out_ready && rxflitv && (m_crd > 0) && (rxflit[18:14] != 5'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_crd   = 0;
    m_lcrdv = 1'b0;
    m_err   = 1'b0;
    m_q.delete();
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int sz;
    bit acc;
    bit byp;
    bit data;
    bit issue;
    int nstate;
    sz    = m_q.size();
    acc   = rxflitv && (m_crd > 0);
    byp   = model_bypass();
    data  = acc && (rxflit[18:14] != 5'd0);
    issue = (m_state == 1) && (m_crd + sz + int'(m_lcrdv) < DEPTH) && (m_crd < 15);
    nstate = m_state;
    if (m_state == 0 && link_act_req && !link_deact_req) nstate = 1;
    else if (m_state == 1 && link_deact_req) nstate = 2;
    else if (m_state == 2 && m_crd == 0 && !m_lcrdv) nstate = 0;
    if (rxflitv && m_crd == 0) m_err = 1'b1;
    if (data && !byp && sz == DEPTH) m_err = 1'b1;
    if (sz > 0 && out_ready) void'(m_q.pop_front());
    if (data && !byp && sz < DEPTH) m_q.push_back(rxflit);
    m_crd   = m_crd + int'(m_lcrdv) - (acc ? 1 : 0);
    m_lcrdv = issue;
    m_state = nstate;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    link_act_req   = 1'b0;
    link_deact_req = 1'b0;
    rxflitv        = 1'b0;
    rxflit         = '0;
    out_ready      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    link_act_req = 1'b1; link_deact_req = 1'b0; rxflitv = 1'b1;
    rxflit = mk_flit(5'd3, 14'h11, 13'h0); out_ready = 1'b1;
    #1;
    total++; if (link_state !== 2'b00) begin bad++; $display("[TB] FAIL reset_state: got %0h want 0", link_state); end
    total++; if (rxlcrdv !== 1'b0) begin bad++; $display("[TB] FAIL reset_rxlcrdv: got %0b want 0", rxlcrdv); end
    total++; if (crd_cnt !== 4'd0) begin bad++; $display("[TB] FAIL reset_crd: got %0d want 0", crd_cnt); end
    total++; if (fifo_cnt !== 3'd0) begin bad++; $display("[TB] FAIL reset_fifo: got %0d want 0", fifo_cnt); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %0b want 0", out_valid); end
    total++; if (out_flit !== '0) begin bad++; $display("[TB] FAIL reset_flit: got %0h want 0", out_flit); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %0b want 0", proto_err); end
    do_reset();
  endtask

  task automatic test_bringup();
    int pulses = 0;
    int first = -1;
    int last = -1;
    link_act_req = 1'b1;
    out_ready    = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (rxlcrdv === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        last = i;
      end
    end
    total++; if (pulses != 4) begin bad++; $display("[TB] FAIL bringup_pulses: got %0d want 4", pulses); end
    total++; if (first != 1 || last != 4) begin bad++; $display("[TB] FAIL bringup_window: got %0d..%0d want 1..4", first, last); end
    total++; if (crd_cnt !== 4'd4) begin bad++; $display("[TB] FAIL bringup_crd: got %0d want 4", crd_cnt); end
    total++; if (link_state !== 2'b01) begin bad++; $display("[TB] FAIL bringup_state: got %0h want 1", link_state); end
  endtask

  task automatic test_fill_drain();
    int seen = 0;
    for (int i = 0; i < 4; i++) begin
      rxflitv = 1'b1;
      rxflit  = mk_flit(5'(i + 1), 14'(14'h100 + i), 13'h0a5);
      cycle();
      seen += int'(rxlcrdv);
    end
    rxflitv = 1'b0;
    #1;
    total++; if (fifo_cnt !== 3'd4) begin bad++; $display("[TB] FAIL fill_fifo: got %0d want 4", fifo_cnt); end
    total++; if (crd_cnt !== 4'd0) begin bad++; $display("[TB] FAIL fill_crd: got %0d want 0", crd_cnt); end
    total++; if (seen != 0) begin bad++; $display("[TB] FAIL fill_nocredit: got %0d pulses want 0", seen); end
    total++; if (out_valid !== 1'b1 || out_flit !== mk_flit(5'd1, 14'h100, 13'h0a5))
      begin bad++; $display("[TB] FAIL fill_head: got v=%0b %0h want v=1 %0h", out_valid, out_flit, mk_flit(5'd1, 14'h100, 13'h0a5)); end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    #1;
    total++; if (fifo_cnt !== 3'd3) begin bad++; $display("[TB] FAIL pop_fifo: got %0d want 3", fifo_cnt); end
    total++; if (out_flit !== mk_flit(5'd2, 14'h101, 13'h0a5))
      begin bad++; $display("[TB] FAIL pop_head: got %0h want %0h", out_flit, mk_flit(5'd2, 14'h101, 13'h0a5)); end
    seen = 0;
    repeat (6) begin cycle(); seen += int'(rxlcrdv); end
    total++; if (seen != 1) begin bad++; $display("[TB] FAIL pop_regrant: got %0d pulses want 1", seen); end
    total++; if (crd_cnt !== 4'd1) begin bad++; $display("[TB] FAIL pop_crd: got %0d want 1", crd_cnt); end
    out_ready = 1'b1;
    repeat (3) cycle();
    out_ready = 1'b0;
    repeat (8) cycle();
    total++; if (crd_cnt !== 4'd4 || fifo_cnt !== 3'd0)
      begin bad++; $display("[TB] FAIL drain_final: got crd=%0d fifo=%0d want 4/0", crd_cnt, fifo_cnt); end
    total++; if (out_valid !== 1'b0 || out_flit !== '0)
      begin bad++; $display("[TB] FAIL drain_idle: got v=%0b %0h want 0/0", out_valid, out_flit); end
  endtask

  task automatic test_lcrdret();
    rxflitv = 1'b1;
    rxflit  = mk_flit(5'd0, 14'h3ff, 13'h1abc);
    cycle();
    rxflitv = 1'b0;
    #1;
    total++; if (crd_cnt !== 4'd3 || fifo_cnt !== 3'd0)
      begin bad++; $display("[TB] FAIL lcrdret_absorb: got crd=%0d fifo=%0d want 3/0", crd_cnt, fifo_cnt); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL lcrdret_novalid: got %0b want 0", out_valid); end
    cycle();
    total++; if (rxlcrdv !== 1'b1) begin bad++; $display("[TB] FAIL lcrdret_regrant: got %0b want 1", rxlcrdv); end
    cycle();
    total++; if (rxlcrdv !== 1'b0 || crd_cnt !== 4'd4)
      begin bad++; $display("[TB] FAIL lcrdret_settle: got v=%0b crd=%0d want 0/4", rxlcrdv, crd_cnt); end
  endtask

  task automatic test_deactivate();
    int seen = 0;
    out_ready = 1'b0;
    rxflitv   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rxflit = mk_flit(5'd7, 14'(14'h200 + i), 13'h0);
      cycle();
    end
    rxflitv = 1'b0;
    #1;
    total++; if (crd_cnt !== 4'd2 || fifo_cnt !== 3'd2)
      begin bad++; $display("[TB] FAIL deact_setup: got crd=%0d fifo=%0d want 2/2", crd_cnt, fifo_cnt); end
    link_act_req   = 1'b0;
    link_deact_req = 1'b1;
    cycle();
    total++; if (link_state !== 2'b10) begin bad++; $display("[TB] FAIL deact_enter: got %0h want 2", link_state); end
    out_ready = 1'b1;
    repeat (2) begin cycle(); seen += int'(rxlcrdv); end
    out_ready = 1'b0;
    total++; if (fifo_cnt !== 3'd0 || link_state !== 2'b10)
      begin bad++; $display("[TB] FAIL deact_fifo_drain: got fifo=%0d st=%0h want 0/2", fifo_cnt, link_state); end
    rxflitv = 1'b1;
    rxflit  = mk_flit(5'd0, 14'h0, 13'h0);
    repeat (2) begin cycle(); seen += int'(rxlcrdv); end
    rxflitv = 1'b0;
    total++; if (crd_cnt !== 4'd0 || link_state !== 2'b10)
      begin bad++; $display("[TB] FAIL deact_returns: got crd=%0d st=%0h want 0/2", crd_cnt, link_state); end
    cycle();
    seen += int'(rxlcrdv);
    total++; if (link_state !== 2'b00) begin bad++; $display("[TB] FAIL deact_stop: got %0h want 0", link_state); end
    total++; if (seen != 0) begin bad++; $display("[TB] FAIL deact_nogrant: got %0d pulses want 0", seen); end
    link_deact_req = 1'b0;
  endtask

  task automatic test_proto_err();
    rxflitv = 1'b1;
    rxflit  = mk_flit(5'd9, 14'h55, 13'h0);
    cycle();
    rxflitv = 1'b0;
    #1;
    total++; if (proto_err !== 1'b1) begin bad++; $display("[TB] FAIL perr_set: got %0b want 1", proto_err); end
    total++; if (fifo_cnt !== 3'd0 || crd_cnt !== 4'd0)
      begin bad++; $display("[TB] FAIL perr_drop: got fifo=%0d crd=%0d want 0/0", fifo_cnt, crd_cnt); end
    link_act_req = 1'b1;
    repeat (8) cycle();
    total++; if (proto_err !== 1'b1 || crd_cnt !== 4'd4)
      begin bad++; $display("[TB] FAIL perr_sticky: got err=%0b crd=%0d want 1/4", proto_err, crd_cnt); end
    rxflitv = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rxflit = mk_flit(5'd4, 14'(i), 13'h0);
      cycle();
    end
    rxflitv = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    total++; if (fifo_cnt !== 3'd0 || crd_cnt !== 4'd0 || out_valid !== 1'b0)
      begin bad++; $display("[TB] FAIL async_rst_clear: got fifo=%0d crd=%0d v=%0b want 0/0/0", fifo_cnt, crd_cnt, out_valid); end
    total++; if (proto_err !== 1'b0 || link_state !== 2'b00)
      begin bad++; $display("[TB] FAIL async_rst_err: got err=%0b st=%0h want 0/0", proto_err, link_state); end
    do_reset();
  endtask

  task automatic test_bypass();
    logic [FW-1:0] f;
    // 0x1234 in the low payload bits with opcode 3, so it is a data flit.
    f = mk_flit(5'd3, 14'h1234, 13'h0);
    link_act_req = 1'b1;
    repeat (8) cycle();
    out_ready = 1'b1;
    rxflitv   = 1'b1;
    rxflit    = f;
    #1;
`ifdef HNI_RXCHAN_BYPASS_EN
    total++; if (out_valid !== 1'b1 || out_flit !== f)
      begin bad++; $display("[TB] FAIL bypass_same_cycle: got v=%0b %0h want 1 %0h", out_valid, out_flit, f); end
`else
    total++; if (out_valid !== 1'b0 || out_flit !== '0)
      begin bad++; $display("[TB] FAIL nobypass_same_cycle: got v=%0b %0h want 0/0", out_valid, out_flit); end
`endif
    cycle();
    rxflitv = 1'b0;
    #1;
`ifdef HNI_RXCHAN_BYPASS_EN
    total++; if (fifo_cnt !== 3'd0 || out_valid !== 1'b0)
      begin bad++; $display("[TB] FAIL bypass_nofifo: got fifo=%0d v=%0b want 0/0", fifo_cnt, out_valid); end
`else
    total++; if (fifo_cnt !== 3'd1 || out_valid !== 1'b1 || out_flit !== f)
      begin bad++; $display("[TB] FAIL nobypass_next: got fifo=%0d v=%0b %0h want 1/1 %0h", fifo_cnt, out_valid, out_flit, f); end
`endif
    repeat (5) cycle();
    total++; if (crd_cnt !== 4'd4 || fifo_cnt !== 3'd0)
      begin bad++; $display("[TB] FAIL bypass_recover: got crd=%0d fifo=%0d want 4/0", crd_cnt, fifo_cnt); end
    do_reset();
  endtask

  task automatic test_random();
    logic          exp_v;
    logic [FW-1:0] exp_f;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      link_act_req   = ($urandom % 8) != 0;
      link_deact_req = ($urandom % 40) == 0;
      if (m_crd > 0) rxflitv = ($urandom % 2) == 1;
      else           rxflitv = ($urandom % 60) == 0;
      rxflit    = mk_flit(5'($urandom % 4), 14'($urandom), 13'($urandom));
      out_ready = ($urandom % 3) != 0;
      #1;
      exp_v = 1'b0;
      exp_f = '0;
      if (m_q.size() > 0) begin exp_v = 1'b1; exp_f = m_q[0]; end
      else if (model_bypass()) begin exp_v = 1'b1; exp_f = rxflit; end
      total++; if (out_valid !== exp_v || out_flit !== exp_f)
        begin bad++; $display("[TB] FAIL rnd_out[%0d]: got v=%0b %0h want v=%0b %0h", i, out_valid, out_flit, exp_v, exp_f); end
      total++; if (link_state !== 2'(m_state) || rxlcrdv !== m_lcrdv)
        begin bad++; $display("[TB] FAIL rnd_link[%0d]: got st=%0h v=%0b want st=%0d v=%0b", i, link_state, rxlcrdv, m_state, m_lcrdv); end
      total++; if (crd_cnt !== 4'(m_crd) || fifo_cnt !== CW'(m_q.size()))
        begin bad++; $display("[TB] FAIL rnd_cnt[%0d]: got crd=%0d fifo=%0d want %0d/%0d", i, crd_cnt, fifo_cnt, m_crd, m_q.size()); end
      total++; if (proto_err !== m_err)
        begin bad++; $display("[TB] FAIL rnd_err[%0d]: got %0b want %0b", i, proto_err, m_err); end
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_fill_drain();
    test_lcrdret();
    test_deactivate();
    test_proto_err();
    test_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
